// File: rtl/rail_sequencer.sv
// N-rail power sequencer: ascending power-up gated on synchronised PG, descending power-down, latched faults.
// Optional build macro RAIL_SEQ_PG_DEBOUNCE_EN adds a per-rail debounce stage behind the PG synchroniser.
module rail_sequencer #(
  parameter int RAILS          = 4,
  parameter int SETTLE_CYCLES  = 1600,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             sysclk,
  input  logic             rst_INV,
  input  logic             enable,
  input  logic             clear_fault,
  input  logic [RAILS-1:0] pg,
  output logic [RAILS-1:0] rail_en,
  output logic             all_good,
  output logic             fault,
  output logic [2:0]       fault_rail,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_SETTLE_UP = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DOWN_LAST    = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_RAIL    = 3'(RAILS - 1);

  state_e           r_state, w_nx_state;
  logic [15:0]      r_cnt, w_nx_cnt;
  logic [2:0]       r_idx, w_nx_idx;
  logic [RAILS-1:0] r_rail_en, w_nx_rail_en;
  logic [2:0]       r_fault_rail, w_nx_fault_rail;
  logic             r_all_good, r_fault;
  logic [RAILS-1:0] r_pg_m, r_pg_q, w_pg_s;
  logic             w_mon_en, w_bad, w_pg_cur;
  logic [2:0]       w_bad_idx;

  always_ff @(posedge sysclk or negedge rst_INV) begin
    if (!rst_INV) begin
      r_pg_m <= '0;
      r_pg_q <= '0;
    end else begin
      r_pg_m <= pg;
      r_pg_q <= r_pg_m;
    end
  end

`ifdef RAIL_SEQ_PG_DEBOUNCE_EN
  logic [RAILS-1:0][1:0] r_db_cnt;
  logic [RAILS-1:0]      r_pg_db;

  // A bit flips only once the synchroniser has disagreed with it for long enough.
  always_ff @(posedge sysclk or negedge rst_INV) begin
    if (!rst_INV) begin
      r_db_cnt <= '0;
      r_pg_db  <= '0;
    end else begin
      for (int k = 0; k < RAILS; k++) begin
        if (r_pg_q[k] == r_pg_db[k]) begin
          r_db_cnt[k] <= 2'd0;
        end else if (r_db_cnt[k] == 2'd2) begin
          r_pg_db[k]  <= r_pg_q[k];
          r_db_cnt[k] <= 2'd0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 2'd1;
        end
      end
    end
  end

  assign w_pg_s = r_pg_db;
`else
  assign w_pg_s = r_pg_q;
`endif

  assign w_mon_en = (r_state == S_RAMP_UP) || (r_state == S_SETTLE_UP) || (r_state == S_ON);

  // Descending scan so the lowest failing rail is the one reported.
  always_comb begin
    w_bad     = 1'b0;
    w_bad_idx = 3'd0;
    w_pg_cur  = 1'b0;
    for (int k = RAILS - 1; k >= 0; k--) begin
      if (3'(k) == r_idx) w_pg_cur = w_pg_s[k];
      if (w_mon_en && !w_pg_s[k] &&
          ((3'(k) < r_idx) || ((3'(k) == r_idx) && (r_state != S_RAMP_UP)))) begin
        w_bad     = 1'b1;
        w_bad_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_nx_state      = r_state;
    w_nx_cnt        = r_cnt;
    w_nx_idx        = r_idx;
    w_nx_rail_en    = r_rail_en;
    w_nx_fault_rail = r_fault_rail;
    case (r_state)
      S_OFF: begin
        if (enable) begin
          w_nx_state      = S_RAMP_UP;
          w_nx_rail_en    = '0;
          w_nx_rail_en[0] = 1'b1;
          w_nx_idx        = 3'd0;
          w_nx_cnt        = 16'd0;
        end
      end
      S_RAMP_UP: begin
        if (w_bad) begin
          w_nx_state      = S_FAULT;
          w_nx_rail_en    = '0;
          w_nx_fault_rail = w_bad_idx;
        end else if (!enable) begin
          w_nx_state = S_RAMP_DOWN;
          w_nx_cnt   = 16'd0;
        end else if (w_pg_cur) begin
          w_nx_state = S_SETTLE_UP;
          w_nx_cnt   = 16'd0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_nx_state      = S_FAULT;
          w_nx_rail_en    = '0;
          w_nx_fault_rail = r_idx;
        end else begin
          w_nx_cnt = r_cnt + 16'd1;
        end
      end
      S_SETTLE_UP: begin
        if (w_bad) begin
          w_nx_state      = S_FAULT;
          w_nx_rail_en    = '0;
          w_nx_fault_rail = w_bad_idx;
        end else if (!enable) begin
          w_nx_state = S_RAMP_DOWN;
          w_nx_cnt   = 16'd0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_nx_cnt = 16'd0;
          if (r_idx == LAST_RAIL) begin
            w_nx_state = S_ON;
          end else begin
            w_nx_state = S_RAMP_UP;
            w_nx_idx   = r_idx + 3'd1;
            for (int k = 0; k < RAILS; k++)
              if (3'(k) == r_idx + 3'd1) w_nx_rail_en[k] = 1'b1;
          end
        end else begin
          w_nx_cnt = r_cnt + 16'd1;
        end
      end
      S_ON: begin
        if (w_bad) begin
          w_nx_state      = S_FAULT;
          w_nx_rail_en    = '0;
          w_nx_fault_rail = w_bad_idx;
        end else if (!enable) begin
          w_nx_state = S_RAMP_DOWN;
          w_nx_cnt   = 16'd0;
        end
      end
      S_RAMP_DOWN: begin
        // Rail idx is dropped on the first cycle here, then settles for SETTLE_CYCLES.
        for (int k = 0; k < RAILS; k++)
          if (3'(k) == r_idx) w_nx_rail_en[k] = 1'b0;
        if (r_cnt == DOWN_LAST) begin
          w_nx_cnt = 16'd0;
          if (r_idx == 3'd0) w_nx_state = S_OFF;
          else               w_nx_idx   = r_idx - 3'd1;
        end else begin
          w_nx_cnt = r_cnt + 16'd1;
        end
      end
      S_FAULT: begin
        w_nx_rail_en = '0;
        if (clear_fault && !enable) begin
          w_nx_state      = S_OFF;
          w_nx_fault_rail = 3'd0;
          w_nx_idx        = 3'd0;
          w_nx_cnt        = 16'd0;
        end
      end
      default: begin
        w_nx_state   = S_OFF;
        w_nx_rail_en = '0;
        w_nx_idx     = 3'd0;
        w_nx_cnt     = 16'd0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_INV) begin
    if (!rst_INV) begin
      r_state      <= S_OFF;
      r_cnt        <= 16'd0;
      r_idx        <= 3'd0;
      r_rail_en    <= '0;
      r_fault_rail <= 3'd0;
      r_all_good   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_nx_state;
      r_cnt        <= w_nx_cnt;
      r_idx        <= w_nx_idx;
      r_rail_en    <= w_nx_rail_en;
      r_fault_rail <= w_nx_fault_rail;
      r_all_good   <= (w_nx_state == S_ON);
      r_fault      <= (w_nx_state == S_FAULT);
    end
  end

  assign rail_en    = r_rail_en;
  assign all_good   = r_all_good;
  assign fault      = r_fault;
  assign fault_rail = r_fault_rail;
  assign state      = r_state;

endmodule
